i2si_frame_ctrl: RTL and testbench

//  Sequences and buffers the I2S input deserializer. It gates the deserializer enable,

---
 rtl/i2si_frame_ctrl_pkg.sv | 18 +
 rtl/i2si_frame_ctrl_if.sv | 37 +++
 rtl/i2si_frame_ctrl_sync_fifo.sv | 62 ++++++
 rtl/i2si_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_i2si_frame_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/i2si_frame_ctrl_pkg.sv
// Shared types and helpers for the I2S input frame controller.
package i2si_frame_ctrl_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    LOST = 2'd3
  } state_e;

  // Eight-bit increment that sticks at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2si_frame_ctrl_if.sv
// Bus between the frame controller, the deserializer and the audio core.
interface i2si_frame_ctrl_if #(
  parameter int DATA_W     = i2si_frame_ctrl_pkg::DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              cfg_en;
  logic              i2si_en;
  logic              i2si_xfc;
  logic [DATA_W-1:0] i2si_lft;
  logic [DATA_W-1:0] i2si_rgt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_lft;
  logic [DATA_W-1:0] out_rgt;
  logic              stat_clr;
  logic              stat_ovf;
  logic              stat_lost;
  logic [7:0]        stat_drop;
  logic [LW-1:0]     stat_level;

  // Controller side.
  modport slave (
    input  cfg_en, i2si_xfc, i2si_lft, i2si_rgt, out_ready, stat_clr,
    output i2si_en, out_valid, out_lft, out_rgt,
           stat_ovf, stat_lost, stat_drop, stat_level
  );

  // Driver side (deserializer, audio core and configuration).
  modport master (
    output cfg_en, i2si_xfc, i2si_lft, i2si_rgt, out_ready, stat_clr,
    input  i2si_en, out_valid, out_lft, out_rgt,
           stat_ovf, stat_lost, stat_drop, stat_level
  );

endinterface

// File: rtl/i2si_frame_ctrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
module i2si_frame_ctrl_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are only visible through a valid head so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/i2si_frame_ctrl.sv
// I2S input frame controller: deserializer gating, start-up discard,
// watchdog resync and buffering of stereo pairs toward the audio core.
module i2si_frame_ctrl
  import i2si_frame_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD    = 2,
  parameter int WDOG_CYC   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  i2si_frame_ctrl_if.slave  bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = 2 * DATA_W;
  localparam int DW = (DISCARD > 1) ? $clog2(DISCARD + 1) : 1;
  localparam int WW = $clog2(WDOG_CYC);
  localparam logic [DW-1:0] DISC_INIT = DW'(DISCARD);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_CYC - 1);

  state_e        state_q;
  logic          en_q;
  logic [DW-1:0] disc_q;
  logic [WW-1:0] wdog_q;
  logic          ovf_q, ovf_d;
  logic          lost_q, lost_d;
  logic [7:0]    drop_q, drop_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_empty, fifo_full;
  logic [PW-1:0] fifo_head;
  logic [LW-1:0] fifo_level;
  logic          run_xfc, wdog_hit, ovf_evt, lost_evt;

  i2si_frame_ctrl_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ({bus.i2si_lft, bus.i2si_rgt}),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .level_o     (fifo_level)
  );

  // Only RUN feeds the FIFO; a full FIFO drops the pair unless the consumer pops this cycle.
  always_comb begin
    fifo_flush = !bus.cfg_en;
    fifo_pop   = !fifo_empty && bus.out_ready;
    run_xfc    = bus.cfg_en && (state_q == RUN) && bus.i2si_xfc;
    fifo_push  = run_xfc && (!fifo_full || fifo_pop);
    ovf_evt    = run_xfc && fifo_full && !fifo_pop;
    wdog_hit   = (wdog_q == WDOG_MAX);
    lost_evt   = bus.cfg_en && ((state_q == SYNC) || (state_q == RUN)) &&
                 !bus.i2si_xfc && wdog_hit;
  end

  // Link state machine with discard counter and frame watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      disc_q  <= '0;
      wdog_q  <= '0;
    end else if (!bus.cfg_en) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      disc_q  <= '0;
      wdog_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= SYNC;
          en_q    <= 1'b1;
          disc_q  <= DISC_INIT;
          wdog_q  <= '0;
        end
        SYNC, RUN: begin
          if (bus.i2si_xfc) begin
            wdog_q <= '0;
            if (state_q == SYNC) begin
              if (disc_q <= DW'(1)) begin
                state_q <= RUN;
                disc_q  <= '0;
              end else begin
                disc_q <= disc_q - DW'(1);
              end
            end
          end else if (wdog_hit) begin
            state_q <= LOST;
            wdog_q  <= '0;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        LOST: begin
          wdog_q <= '0;
          if (bus.i2si_xfc) begin
            state_q <= SYNC;
            disc_q  <= DISC_INIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A new event in the same cycle as a clear wins over the clear.
  always_comb begin
    ovf_d  = ovf_q;
    lost_d = lost_q;
    drop_d = drop_q;
    if (bus.stat_clr) begin
      ovf_d  = 1'b0;
      lost_d = 1'b0;
      drop_d = '0;
    end
    if (ovf_evt) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc8(drop_d);
    end
    if (lost_evt) lost_d = 1'b1;
  end

  // Sticky status registers; untouched by disabling the receive path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      lost_q <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      lost_q <= lost_d;
      drop_q <= drop_d;
    end
  end

  assign bus.i2si_en    = en_q;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_lft    = fifo_empty ? '0 : fifo_head[PW-1:DATA_W];
  assign bus.out_rgt    = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign bus.stat_ovf   = ovf_q;
  assign bus.stat_lost  = lost_q;
  assign bus.stat_drop  = drop_q;
  assign bus.stat_level = fifo_level;

endmodule

// File: tb/tb_i2si_frame_ctrl.sv
// Directed self-checking bench for i2si_frame_ctrl with a pair scoreboard.
module tb_i2si_frame_ctrl;
  import i2si_frame_ctrl_pkg::*;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int DISCARD    = 2;
  localparam int WDOG_CYC   = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [2*DATA_W-1:0] sbq [$];

  i2si_frame_ctrl_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  i2si_frame_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DISCARD    (DISCARD),
    .WDOG_CYC   (WDOG_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One xfc pulse; pairs the controller should keep go to the scoreboard.
  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input bit keep);
    bus.i2si_lft = l;
    bus.i2si_rgt = r;
    bus.i2si_xfc = 1'b1;
    if (keep) sbq.push_back({l, r});
    tick();
    bus.i2si_xfc = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32 && sbq.size() != 0; i++) tick();
    tick();
    checkOutput({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    checkOutput({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Scoreboard: every accepted head must match the oldest expected pair.
  always @(negedge clk) begin
    logic [31:0] expv;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $error("[TB] FAIL sb_unexpected: observed=0x%0h expected=none",
               {bus.out_lft, bus.out_rgt});
      end else begin
        expv = sbq.pop_front();
        assert ({bus.out_lft, bus.out_rgt} === expv) else begin
          errors++;
          $error("[TB] FAIL sb_pair: observed=0x%0h expected=0x%0h",
                 {bus.out_lft, bus.out_rgt}, expv);
        end
      end
    end
  end

  initial begin
    bus.cfg_en    = 1'b0;
    bus.i2si_xfc  = 1'b0;
    bus.i2si_lft  = '0;
    bus.i2si_rgt  = '0;
    bus.out_ready = 1'b0;
    bus.stat_clr  = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_en",    32'(bus.i2si_en), 32'd0);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_lft",   32'(bus.out_lft), 32'd0);
    checkOutput("rst_rgt",   32'(bus.out_rgt), 32'd0);
    checkOutput("rst_ovf",   32'(bus.stat_ovf), 32'd0);
    checkOutput("rst_lost",  32'(bus.stat_lost), 32'd0);
    checkOutput("rst_drop",  32'(bus.stat_drop), 32'd0);
    checkOutput("rst_level", 32'(bus.stat_level), 32'd0);

    repeat (2) @(posedge clk);
    #3;
    bus.cfg_en = 1'b1;
    rst_n      = 1'b1;
    tick();
    checkOutput("t1_sync", 32'(dut.state_q), 32'(SYNC));
    checkOutput("t1_en",   32'(bus.i2si_en), 32'd1);

    $display("[TB] test 1: start-up discard");
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(16'(k), 16'(k + 1), k > 2);
      if (k == 1) checkOutput("t1_still_sync", 32'(dut.state_q), 32'(SYNC));
      if (k == 2) checkOutput("t1_run", 32'(dut.state_q), 32'(RUN));
      if (k == 2) checkOutput("t1_no_valid", 32'(bus.out_valid), 32'd0);
      if (k == 3) checkOutput("t1_latency", 32'(bus.out_valid), 32'd1);
      tick();
    end
    waitDrain("t1");
    checkOutput("t1_drop", 32'(bus.stat_drop), 32'd0);
    checkOutput("t1_ovf",  32'(bus.stat_ovf), 32'd0);

    $display("[TB] test 2: overflow");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus(16'h0100 + 16'(k), 16'h0200 + 16'(k), k < 4);
    checkOutput("t2_level", 32'(bus.stat_level), 32'd4);
    checkOutput("t2_ovf",   32'(bus.stat_ovf), 32'd1);
    checkOutput("t2_drop",  32'(bus.stat_drop), 32'd2);
    checkOutput("t2_head",  32'(bus.out_lft), 32'h0100);

    $display("[TB] test 3: full with pop and push together");
    bus.out_ready = 1'b1;
    applyStimulus(16'h01AA, 16'h02AA, 1'b1);
    bus.out_ready = 1'b0;
    checkOutput("t3_level", 32'(bus.stat_level), 32'd4);
    checkOutput("t3_drop",  32'(bus.stat_drop), 32'd2);
    waitDrain("t3");

    $display("[TB] test 4: watchdog");
    applyStimulus(16'h0301, 16'h0302, 1'b1);
    repeat (WDOG_CYC - 1) tick();
    checkOutput("t4_pre_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("t4_pre_lost",  32'(bus.stat_lost), 32'd0);
    tick();
    checkOutput("t4_state", 32'(dut.state_q), 32'(LOST));
    checkOutput("t4_lost",  32'(bus.stat_lost), 32'd1);
    checkOutput("t4_en",    32'(bus.i2si_en), 32'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'h0400 + 16'(k), 16'h0500 + 16'(k), k >= 3);
      if (k == 0) checkOutput("t4_resync", 32'(dut.state_q), 32'(SYNC));
      if (k == 2) checkOutput("t4_run", 32'(dut.state_q), 32'(RUN));
      tick();
    end
    waitDrain("t4");

    $display("[TB] test 5: disable flush and clear");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(16'h0600 + 16'(k), 16'h0700 + 16'(k), 1'b0);
    checkOutput("t5_level3", 32'(bus.stat_level), 32'd3);
    bus.cfg_en = 1'b0;
    applyStimulus(16'h0777, 16'h0778, 1'b0);
    checkOutput("t5_en",    32'(bus.i2si_en), 32'd0);
    checkOutput("t5_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("t5_ovf",   32'(bus.stat_ovf), 32'd1);
    checkOutput("t5_lost",  32'(bus.stat_lost), 32'd1);
    checkOutput("t5_drop",  32'(bus.stat_drop), 32'd2);
    tick();
    checkOutput("t5_level0", 32'(bus.stat_level), 32'd0);
    bus.cfg_en = 1'b1;
    tick();
    applyStimulus(16'h0A01, 16'h0B01, 1'b0);
    applyStimulus(16'h0A02, 16'h0B02, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(16'h0800 + 16'(k), 16'h0900 + 16'(k), 1'b1);
    checkOutput("t5_full", 32'(bus.stat_level), 32'd4);
    bus.stat_clr = 1'b1;
    applyStimulus(16'h08FF, 16'h09FF, 1'b0);
    bus.stat_clr = 1'b0;
    checkOutput("t5_clr_ovf",  32'(bus.stat_ovf), 32'd1);
    checkOutput("t5_clr_drop", 32'(bus.stat_drop), 32'd1);
    checkOutput("t5_clr_lost", 32'(bus.stat_lost), 32'd0);
    bus.stat_clr = 1'b1;
    tick();
    bus.stat_clr = 1'b0;
    checkOutput("t5_clr2_ovf",  32'(bus.stat_ovf), 32'd0);
    checkOutput("t5_clr2_drop", 32'(bus.stat_drop), 32'd0);
    waitDrain("t5");

    $display("[TB] test 6: asynchronous reset");
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(16'h0C00 + 16'(k), 16'h0D00 + 16'(k), 1'b0);
    checkOutput("t6_pre_ovf", 32'(bus.stat_ovf), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_en",    32'(bus.i2si_en), 32'd0);
    checkOutput("t6_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_lft",   32'(bus.out_lft), 32'd0);
    checkOutput("t6_ovf",   32'(bus.stat_ovf), 32'd0);
    checkOutput("t6_drop",  32'(bus.stat_drop), 32'd0);
    checkOutput("t6_level", 32'(bus.stat_level), 32'd0);
    bus.cfg_en = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
    checkOutput("t6_idle",    32'(dut.state_q), 32'(IDLE));
    checkOutput("t6_en_idle", 32'(bus.i2si_en), 32'd0);
    checkOutput("final_sb", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
